// File: rtl/latch_out_pkg.sv
// Shared definitions for the latch-output debounce path: FSM encoding and
// default parameter values reused by every latch-output consumer.
package latch_out_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } db_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_WIDTH       = 8;

endpackage

// File: rtl/sync_chain.sv
// N-stage reset-to-0 synchronizer bringing an asynchronous level into CLK.
module sync_chain #(
    parameter int N = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stages <= '0;
        end else begin
            stages <= {stages[N-2:0], d};
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/latch_out_debounce.sv
// Synchronizes a latch Q level, debounces it, and emits a clean level,
// rise/fall pulses and a saturating count of qualified rising events.
module latch_out_debounce
    import latch_out_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Q_in,
    input  logic                 EN,
    input  logic                 cnt_clr,
    output logic                 Q_stable,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_WIDTH-1:0] event_cnt
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic            s;
    db_state_t       state;
    logic [DB_W-1:0] db_cnt;

    sync_chain #(.N(SYNC_STAGES)) u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (Q_in),
        .q   (s)
    );

    // Debounce FSM; Q_stable and pulses are registered together with the state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= STABLE_LOW;
            db_cnt     <= '0;
            Q_stable   <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state      <= STABLE_HIGH;
                            db_cnt     <= '0;
                            Q_stable   <= 1'b1;
                            rise_pulse <= 1'b1;
                        end else begin
                            state  <= CHECK_HIGH;
                            db_cnt <= DB_ONE;
                        end
                    end
                end
                CHECK_HIGH: begin
                    if (!s) begin
                        state  <= STABLE_LOW;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state      <= STABLE_HIGH;
                        db_cnt     <= '0;
                        Q_stable   <= 1'b1;
                        rise_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state      <= STABLE_LOW;
                            db_cnt     <= '0;
                            Q_stable   <= 1'b0;
                            fall_pulse <= 1'b1;
                        end else begin
                            state  <= CHECK_LOW;
                            db_cnt <= DB_ONE;
                        end
                    end
                end
                CHECK_LOW: begin
                    if (s) begin
                        state  <= STABLE_HIGH;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state      <= STABLE_LOW;
                        db_cnt     <= '0;
                        Q_stable   <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
            endcase
        end
    end

    // Counter follows the registered pulse, so it settles one cycle after it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            event_cnt <= '0;
        end else if (cnt_clr) begin
            event_cnt <= '0;
        end else if (rise_pulse && EN) begin
            event_cnt <= sat_inc(event_cnt);
        end
    end

endmodule

// File: doc/latch_out_debounce.md
# latch_out_debounce

Downstream consumer of the gated D-latch with active-low clear. It brings the latch's asynchronous Q level into the CLK domain through a synchronizer chain, then filters glitches with a debounce state machine. It emits a clean level plus one-cycle rise/fall pulses and keeps a saturating count of qualified rising events. Each latch output that feeds clocked logic sits behind one instance.

## Interface
- SYNC_STAGES, 2, number of synchronizer flops (legal ≥2)
- DEBOUNCE_CYCLES, 4, consecutive equal synchronized samples required to accept a level change (legal ≥1)
- CNT_WIDTH, 8, width of event counter
- CLK  input  1  single clock; all state changes on rising edge
- RST  input  1  reset, asynchronous, active-high; one clock domain, no other reset
- Q_in  input  1  latch Q output, asynchronous to CLK
- EN  input  1  event counter enable
- cnt_clr  input  1  synchronous clear of event_cnt
- Q_stable  output  1  debounced, synchronized level
- rise_pulse  output  1  one-cycle pulse when Q_stable goes 0→1
- fall_pulse  output  1  one-cycle pulse when Q_stable goes 1→0
- event_cnt  output  CNT_WIDTH  count of qualified rising events

## Operation
- Sync chain: SYNC_STAGES flops, reset to 0; last stage output is s.
- FSM states: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW; db_cnt counts accepted samples, width $clog2(DEBOUNCE_CYCLES)+1.
- STABLE_LOW: s=1 → CHECK_HIGH, db_cnt=1; if DEBOUNCE_CYCLES=1 go straight to STABLE_HIGH.
- CHECK_HIGH: s=0 → STABLE_LOW, db_cnt=0 (glitch rejected, no pulse); s=1 and db_cnt=DEBOUNCE_CYCLES-1 → STABLE_HIGH; else db_cnt+1.
- STABLE_HIGH / CHECK_LOW: mirror image with s inverted.
- Q_stable registered: 1 in STABLE_HIGH and CHECK_LOW, 0 otherwise.
- rise_pulse registered, high exactly the cycle after entry to STABLE_HIGH. fall_pulse is the same for STABLE_LOW entry from CHECK_LOW. Never both high.
- event_cnt: cnt_clr=1 → 0 (priority over increment). Else rise_pulse=1 and EN=1 → +1, saturating at all-ones (no wrap). Else hold.
- EN gates only the counter; FSM and pulses run regardless.

## Timing
- Reset: async assert clears sync flops, state=STABLE_LOW, db_cnt=0, Q_stable=0, rise_pulse=0, fall_pulse=0, event_cnt=0, all immediately without a clock.
- Latency: Q_in change settled before edge n, held steady → Q_stable updates at edge n+SYNC_STAGES+DEBOUNCE_CYCLES-1 (defaults: n+5). Pulse is visible in the same cycle as the new Q_stable.
- Minimum accepted pulse width on Q_in: DEBOUNCE_CYCLES clock periods. Shorter excursions produce no output change.
- Reset asserted mid-debounce: check state abandoned, no pulse emitted.
- Reset released with Q_in=1: treated as a normal 0→1 edge; rise_pulse fires after the full latency.
- cnt_clr coincident with rise_pulse: counter ends at 0; the event is lost by design.
- Back-to-back events: minimum spacing between rise_pulses is 2·DEBOUNCE_CYCLES cycles.

## Structure
- Shared package latch_out_pkg: FSM state encoding (2-bit: STABLE_LOW=0, CHECK_HIGH=1, STABLE_HIGH=2, CHECK_LOW=3) and default parameter constants.
- Sub-module sync_chain (parameter N, ports CLK, RST, d, q): N-stage reset-to-0 synchronizer, reusable for other latch outputs.
- Top: sync_chain instance, FSM with db_cnt, output registers, event counter.

## Test plan
- Reset with Q_in=1: assert RST mid-cycle → all outputs 0 asynchronously. Release before edge 0 → Q_stable=1 and rise_pulse=1 after edge 5, event_cnt=1 (EN=1).
- Glitch rejection: Q_in high for 3 cycles then low → Q_stable stays 0, no pulses, event_cnt unchanged. High for 4 cycles → accepted.
- Falling edge: from Q_stable=1, drop Q_in before edge n → Q_stable=0 and fall_pulse=1 at edge n+5 only. rise_pulse stays 0.
- Counter: CNT_WIDTH=2, five qualified rises with EN=1 → event_cnt 1,2,3,3,3. EN=0 on a sixth rise → no change. cnt_clr coincident with a rise → 0.
- Reset mid-debounce: Q_in high, assert RST at second CHECK_HIGH cycle, release with Q_in high → single rise_pulse after the full latency from release.
- Random Q_in toggling driven by a latch model (G toggling every cycle, CLRn random) → Q_stable always equals a value Q_in held for ≥4 cycles. Exactly one pulse per Q_stable transition.
